// File: rtl/prefetch_queue_pkg.sv
// prefetch_queue_pkg: shared widths, word stride and FSM encoding for the prefetch queue
`ifndef ADDRESS_WIDTH
`define ADDRESS_WIDTH 32
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

package prefetch_queue_pkg;
    localparam int PQ_WORD_BYTES = `DATA_WIDTH / 8;
    typedef enum logic {PQ_RUN = 1'b0, PQ_DRAIN = 1'b1} pq_state_e;
endpackage

// File: rtl/pq_fifo.sv
// pq_fifo: synchronous in-order FIFO with flush, occupancy count and head view
module pq_fifo #(
    parameter int W = 64,
    parameter int DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    push,
    input  logic                    pop,
    input  logic                    flush,
    input  logic [W-1:0]            din,
    output logic [$clog2(DEPTH):0]  count,
    output logic [W-1:0]            head
);
    localparam int AW = $clog2(DEPTH);
    logic [W-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    assign head = mem[rd_ptr];
    always_ff @(posedge clk) begin
        if (!reset || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            count <= count + (AW+1)'(push) - (AW+1)'(pop);
        end
    end
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= din;
    end
    // the credit scheme upstream must make a full-FIFO push unreachable
    always_ff @(posedge clk) begin
        if (reset && !flush && push) assert (count != (AW+1)'(DEPTH));
    end
endmodule

// File: rtl/prefetch_queue.sv
// prefetch_queue: sequential instruction prefetcher with redirect flush; PREFETCH_STATS_EN adds discard/stall counters
module prefetch_queue
    import prefetch_queue_pkg::*;
#(
    parameter int ADDR_W = `ADDRESS_WIDTH,
    parameter int DATA_W = `DATA_WIDTH,
    parameter int DEPTH = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              reset,
`ifdef PREFETCH_STATS_EN
    output logic [15:0]       o_stat_discard,
    output logic [15:0]       o_stat_stall,
`endif
    input  logic              i_redirect_valid,
    input  logic [ADDR_W-1:0] i_redirect_pc,
    output logic              o_mem_valid,
    output logic [ADDR_W-1:0] o_mem_addr,
    input  logic              i_mem_ready,
    input  logic              i_mem_res_valid,
    input  logic [DATA_W-1:0] i_mem_data,
    output logic              o_valid,
    output logic [DATA_W-1:0] o_data,
    output logic [ADDR_W-1:0] o_addr,
    input  logic              i_ready
);
    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [ADDR_W-1:0] STRIDE = ADDR_W'(PQ_WORD_BYTES);
    pq_state_e state, state_n;
    logic [ADDR_W-1:0] req_pc, req_pc_n, resp_pc, resp_pc_n, aligned_pc;
    logic [CW-1:0] inflight, inflight_n, discard, discard_n, count;
    logic [ADDR_W+DATA_W-1:0] head;
    logic mem_fire, push, pop;

    assign aligned_pc = i_redirect_pc & ~(STRIDE - 1'b1);
    // buffered plus outstanding words never exceed DEPTH, so responses always fit
    assign o_mem_valid = reset && state == PQ_RUN && count + inflight < CW'(DEPTH);
    assign o_mem_addr = req_pc;
    assign mem_fire = o_mem_valid && i_mem_ready;
    assign push = i_mem_res_valid && state == PQ_RUN && discard == '0 && !i_redirect_valid;
    assign o_valid = count != '0;
    assign pop = o_valid && i_ready && !i_redirect_valid;
    assign {o_addr, o_data} = o_valid ? head : '0;

    pq_fifo #(.W(ADDR_W + DATA_W), .DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .flush (i_redirect_valid),
        .din   ({resp_pc, i_mem_data}),
        .count (count),
        .head  (head)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state    <= PQ_RUN;
            req_pc   <= RESET_PC;
            resp_pc  <= RESET_PC;
            inflight <= '0;
            discard  <= '0;
        end else begin
            state    <= state_n;
            req_pc   <= req_pc_n;
            resp_pc  <= resp_pc_n;
            inflight <= inflight_n;
            discard  <= discard_n;
        end
    end

    always_comb begin
        state_n    = state;
        req_pc_n   = req_pc;
        resp_pc_n  = resp_pc;
        inflight_n = inflight;
        discard_n  = discard;
        if (i_redirect_valid) begin
            // in RUN discard is zero; in DRAIN inflight is zero and nothing fires
            req_pc_n   = aligned_pc;
            resp_pc_n  = aligned_pc;
            discard_n  = discard + inflight + CW'(mem_fire) - CW'(i_mem_res_valid);
            inflight_n = '0;
            state_n    = discard_n != '0 ? PQ_DRAIN : PQ_RUN;
        end else if (state == PQ_DRAIN) begin
            discard_n = discard - CW'(i_mem_res_valid);
            state_n   = discard_n == '0 ? PQ_RUN : PQ_DRAIN;
        end else begin
            req_pc_n   = mem_fire ? req_pc + STRIDE : req_pc;
            resp_pc_n  = push ? resp_pc + STRIDE : resp_pc;
            inflight_n = inflight + CW'(mem_fire) - CW'(push);
        end
    end

`ifdef PREFETCH_STATS_EN
    always_ff @(posedge clk) begin
        if (!reset) begin
            o_stat_discard <= '0;
            o_stat_stall   <= '0;
        end else begin
            if (i_mem_res_valid && !push && o_stat_discard != '1) o_stat_discard <= o_stat_discard + 1'b1;
            if (i_ready && !o_valid && o_stat_stall != '1) o_stat_stall <= o_stat_stall + 1'b1;
        end
    end
`endif
endmodule

// File: tb/tb_prefetch_queue.sv
// tb_prefetch_queue: random and directed stimulus against a queue-level model of the prefetcher
module tb_prefetch_queue;
    localparam int DEPTH = 4;

    typedef struct {
        logic [31:0] addr;
        int          epoch;
        int          due;
    } req_t;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        i_redirect_valid = 1'b0;
    logic [31:0] i_redirect_pc = '0;
    logic        i_mem_ready = 1'b0;
    logic        i_mem_res_valid = 1'b0;
    logic [31:0] i_mem_data = '0;
    logic        i_ready = 1'b0;
    logic        o_mem_valid, o_valid;
    logic [31:0] o_mem_addr, o_data, o_addr;
`ifdef PREFETCH_STATS_EN
    logic [15:0] o_stat_discard, o_stat_stall;
    logic [15:0] m_disc = '0, m_stall = '0;
`endif

    req_t        mq[$];
    logic [31:0] fq[$];
    logic [31:0] pop_log[$];
    logic [31:0] req_log[$];
    logic [31:0] req_addr = '0;
    int          total = 0, bad = 0, cyc = 0, epoch = 0;
    int          lat_min = 1, lat_max = 1, resp_pct = 100;
    bit          model_ok = 0, in_rst = 0;

    prefetch_queue dut (
        .clk              (clk),
        .reset            (reset),
`ifdef PREFETCH_STATS_EN
        .o_stat_discard   (o_stat_discard),
        .o_stat_stall     (o_stat_stall),
`endif
        .i_redirect_valid (i_redirect_valid),
        .i_redirect_pc    (i_redirect_pc),
        .o_mem_valid      (o_mem_valid),
        .o_mem_addr       (o_mem_addr),
        .i_mem_ready      (i_mem_ready),
        .i_mem_res_valid  (i_mem_res_valid),
        .i_mem_data       (i_mem_data),
        .o_valid          (o_valid),
        .o_data           (o_data),
        .o_addr           (o_addr),
        .i_ready          (i_ready)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mw(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // one clock: drive at negedge, compare, then advance the model at posedge
    task automatic cycle();
        int stale = 0, cur = 0;
        bit exp_ov, exp_mv, rv, fire;
        req_t r;
        rv = reset && mq.size() > 0 && mq[0].due <= cyc && $urandom_range(99) < resp_pct;
        i_mem_res_valid = rv;
        i_mem_data = rv ? mw(mq[0].addr) : $urandom;
        #1;
        foreach (mq[i]) if (mq[i].epoch != epoch) stale++; else cur++;
        exp_ov = fq.size() != 0;
        exp_mv = reset && stale == 0 && fq.size() + cur < DEPTH;
        if (model_ok) begin
            chk("o_valid", 64'(o_valid), 64'(exp_ov));
            chk("o_mem_valid", 64'(o_mem_valid), 64'(exp_mv));
            chk("o_mem_addr", 64'(o_mem_addr), 64'(req_addr));
            if (exp_ov) begin
                chk("o_addr", 64'(o_addr), 64'(fq[0]));
                chk("o_data", 64'(o_data), 64'(mw(fq[0])));
            end else if (in_rst) begin
                chk("rst_o_addr", 64'(o_addr), 64'(0));
                chk("rst_o_data", 64'(o_data), 64'(0));
            end
`ifdef PREFETCH_STATS_EN
            chk("stat_discard", 64'(o_stat_discard), 64'(m_disc));
            chk("stat_stall", 64'(o_stat_stall), 64'(m_stall));
`endif
        end
        if (reset && o_valid && i_ready && !i_redirect_valid) pop_log.push_back(o_addr);
        if (o_mem_valid && i_mem_ready) req_log.push_back(o_mem_addr);
        @(posedge clk);
        if (!reset) begin
            mq.delete();
            fq.delete();
            req_addr = '0;
            epoch++;
            in_rst = 1;
            model_ok = 1;
`ifdef PREFETCH_STATS_EN
            m_disc = '0;
            m_stall = '0;
`endif
        end else begin
            in_rst = 0;
            fire = exp_mv && i_mem_ready;
            if (rv) begin
                r = mq.pop_front();
                if (r.epoch == epoch && !i_redirect_valid) fq.push_back(r.addr);
`ifdef PREFETCH_STATS_EN
                else if (m_disc != 16'hFFFF) m_disc++;
`endif
            end
`ifdef PREFETCH_STATS_EN
            if (i_ready && !exp_ov && m_stall != 16'hFFFF) m_stall++;
`endif
            if (exp_ov && i_ready && !i_redirect_valid) void'(fq.pop_front());
            if (fire) begin
                r.addr = req_addr;
                r.epoch = epoch;
                r.due = cyc + $urandom_range(lat_max, lat_min);
                mq.push_back(r);
            end
            if (i_redirect_valid) begin
                fq.delete();
                epoch++;
                req_addr = i_redirect_pc & ~32'h3;
            end else if (fire) begin
                req_addr += 32'd4;
            end
        end
        @(negedge clk);
        cyc++;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic do_reset();
        reset = 1'b0;
        i_redirect_valid = 1'b0;
        run(2);
        chk("rst_o_valid", 64'(o_valid), 64'(0));
        chk("rst_o_mem_valid", 64'(o_mem_valid), 64'(0));
        chk("rst_o_data_lit", 64'(o_data), 64'(0));
        chk("rst_o_addr_lit", 64'(o_addr), 64'(0));
        reset = 1'b1;
        #1;
        chk("post_rst_mem_valid", 64'(o_mem_valid), 64'(1));
        chk("post_rst_mem_addr", 64'(o_mem_addr), 64'(0));
        pop_log.delete();
        req_log.delete();
    endtask

    initial begin
        bit seen, gap;
        // streaming with single-cycle memory
        i_mem_ready = 1'b1;
        i_ready = 1'b1;
        do_reset();
        seen = 0;
        gap = 0;
        for (int i = 0; i < 12; i++) begin
            cycle();
            if (seen && !o_valid) gap = 1;
            if (o_valid) seen = 1;
        end
        chk("a_seen", 64'(seen), 64'(1));
        chk("a_gap", 64'(gap), 64'(0));
        chk("a_pop0", 64'(pop_log[0]), 64'h0);
        chk("a_pop1", 64'(pop_log[1]), 64'h4);
        chk("a_pop2", 64'(pop_log[2]), 64'h8);
        chk("a_pop3", 64'(pop_log[3]), 64'hC);

        // fetch stalled: credits cap requests at DEPTH
        i_ready = 1'b0;
        do_reset();
        run(10);
        chk("b_nreq", 64'(req_log.size()), 64'(4));
        chk("b_req3", 64'(req_log[3]), 64'hC);
        chk("b_mem_valid_off", 64'(o_mem_valid), 64'(0));
        i_ready = 1'b1;
        cycle();
        i_ready = 1'b0;
        chk("b_mem_valid_on", 64'(o_mem_valid), 64'(1));
        chk("b_mem_addr", 64'(o_mem_addr), 64'h10);
        chk("b_pop0", 64'(pop_log[0]), 64'h0);

        // redirect with two responses in flight
        lat_min = 4;
        lat_max = 4;
        i_mem_ready = 1'b1;
        i_ready = 1'b1;
        do_reset();
        run(2);
        i_mem_ready = 1'b0;
        i_redirect_valid = 1'b1;
        i_redirect_pc = 32'h103;
        cycle();
        i_redirect_valid = 1'b0;
        i_mem_ready = 1'b1;
        chk("c_drain_mem_valid", 64'(o_mem_valid), 64'(0));
        chk("c_drain_mem_addr", 64'(o_mem_addr), 64'h100);
        chk("c_drain_o_valid", 64'(o_valid), 64'(0));
        pop_log.delete();
        req_log.delete();
        run(15);
        chk("c_req0", 64'(req_log[0]), 64'h100);
        chk("c_pop0", 64'(pop_log[0]), 64'h100);
`ifdef PREFETCH_STATS_EN
        chk("c_stat_discard", 64'(o_stat_discard), 64'(2));
`endif

        // redirect with a full FIFO and nothing outstanding
        lat_min = 1;
        lat_max = 1;
        i_ready = 1'b0;
        do_reset();
        run(8);
        i_redirect_valid = 1'b1;
        i_redirect_pc = 32'h200;
        cycle();
        i_redirect_valid = 1'b0;
        chk("d_o_valid", 64'(o_valid), 64'(0));
        chk("d_mem_valid", 64'(o_mem_valid), 64'(1));
        chk("d_mem_addr", 64'(o_mem_addr), 64'h200);

        // address wrap at the top of the space
        i_ready = 1'b1;
        i_redirect_valid = 1'b1;
        i_redirect_pc = 32'hFFFF_FFFC;
        cycle();
        i_redirect_valid = 1'b0;
        pop_log.delete();
        req_log.delete();
        run(12);
        chk("e_req0", 64'(req_log[0]), 64'hFFFF_FFFC);
        chk("e_req1", 64'(req_log[1]), 64'h0);
        chk("e_pop0", 64'(pop_log[0]), 64'hFFFF_FFFC);
        chk("e_pop1", 64'(pop_log[1]), 64'h0);

        // randomized traffic with a reset in the middle
        lat_min = 1;
        lat_max = 4;
        resp_pct = 75;
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            if (i == 1500) do_reset();
            i_mem_ready = $urandom_range(99) < 70;
            i_ready = $urandom_range(99) < 60;
            i_redirect_valid = $urandom_range(99) < 3;
            i_redirect_pc = $urandom_range(3) == 0 ? 32'hFFFF_FFF0 + 32'($urandom_range(15)) : $urandom;
            cycle();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
